// File: rtl/conv_tile_sched_if.sv
// Handshake bundle between the tile sequencer, the host and the engines.
// TILE_SCHED_PERF_EN adds the perf counter outputs.
interface conv_tile_sched_if #(
    parameter int IW = 8
);
    logic          sched_start;
    logic          sched_abort;
    logic          sched_busy;
    logic          sched_done;
    logic          in_ld_start;
    logic          in_ld_done;
    logic          w_ld_start;
    logic          w_ld_done;
    logic          conv_start;
    logic          conv_done;
    logic          out_clr;
    logic          st_start;
    logic          st_done;
    logic [IW-1:0] n_idx;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] c_idx;
    logic [IW-1:0] m_idx;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]   perf_busy_cyc;
    logic [31:0]   perf_conv_cyc;

    modport master (
        input  sched_start, sched_abort,
        input  in_ld_done, w_ld_done,
        input  conv_done, st_done,
        output sched_busy, sched_done,
        output in_ld_start, w_ld_start,
        output conv_start, st_start,
        output out_clr,
        output n_idx, r_idx, c_idx, m_idx,
        output perf_busy_cyc, perf_conv_cyc
    );

    modport slave (
        output sched_start, sched_abort,
        output in_ld_done, w_ld_done,
        output conv_done, st_done,
        input  sched_busy, sched_done,
        input  in_ld_start, w_ld_start,
        input  conv_start, st_start,
        input  out_clr,
        input  n_idx, r_idx, c_idx, m_idx,
        input  perf_busy_cyc, perf_conv_cyc
    );
`else
    modport master (
        input  sched_start, sched_abort,
        input  in_ld_done, w_ld_done,
        input  conv_done, st_done,
        output sched_busy, sched_done,
        output in_ld_start, w_ld_start,
        output conv_start, st_start,
        output out_clr,
        output n_idx, r_idx, c_idx, m_idx
    );

    modport slave (
        output sched_start, sched_abort,
        output in_ld_done, w_ld_done,
        output conv_done, st_done,
        input  sched_busy, sched_done,
        input  in_ld_start, w_ld_start,
        input  conv_start, st_start,
        input  out_clr,
        input  n_idx, r_idx, c_idx, m_idx
    );
`endif
endinterface

// File: rtl/conv_tile_sched.sv
// Layer tile sequencer: walks n/r/c/m tiles and pulses load, conv and store engines.
// Define TILE_SCHED_PERF_EN to add the busy/conv cycle counters.
module conv_tile_sched #(
    parameter int NR = 4,
    parameter int NC = 4,
    parameter int NM = 2,
    parameter int NN = 2,
    parameter int IW = 8
) (
    input logic               clk,
    input logic               rst,
    conv_tile_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LD_IN,
        LD_W,
        CONV,
        ST,
        FIN
    } state_t;

    localparam logic [IW-1:0] N_LAST = IW'(NN - 1);
    localparam logic [IW-1:0] R_LAST = IW'(NR - 1);
    localparam logic [IW-1:0] C_LAST = IW'(NC - 1);
    localparam logic [IW-1:0] M_LAST = IW'(NM - 1);
    localparam logic [IW-1:0] ONE    = IW'(1);

    state_t        state;
    logic          busy_q;
    logic          done_q;
    logic          in_ld_q;
    logic          w_ld_q;
    logic          conv_q;
    logic          st_q;
    logic          clr_q;
    logic [IW-1:0] n_q;
    logic [IW-1:0] r_q;
    logic [IW-1:0] c_q;
    logic [IW-1:0] m_q;

    logic start_ok;
    logic abort_ok;
    logic in_ok;
    logic w_ok;
    logic conv_ok;
    logic st_ok;
    logic last_tile;

    // A done is only believed once its start pulse has been issued.
    assign start_ok  = (state == IDLE) && bus.sched_start;
    assign abort_ok  = (state != IDLE) && bus.sched_abort;
    assign in_ok     = (state == LD_IN) && !in_ld_q && bus.in_ld_done;
    assign w_ok      = (state == LD_W) && !w_ld_q && bus.w_ld_done;
    assign conv_ok   = (state == CONV) && !conv_q && bus.conv_done;
    assign st_ok     = (state == ST) && !st_q && bus.st_done;
    assign last_tile = (n_q == N_LAST) && (r_q == R_LAST) &&
                       (c_q == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            in_ld_q <= 1'b0;
            w_ld_q  <= 1'b0;
            conv_q  <= 1'b0;
            st_q    <= 1'b0;
            clr_q   <= 1'b0;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            m_q     <= '0;
        end else begin
            in_ld_q <= 1'b0;
            w_ld_q  <= 1'b0;
            conv_q  <= 1'b0;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
            if (abort_ok) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                clr_q  <= 1'b0;
                n_q    <= '0;
                r_q    <= '0;
                c_q    <= '0;
                m_q    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state   <= LD_IN;
                            busy_q  <= 1'b1;
                            in_ld_q <= 1'b1;
                            n_q     <= '0;
                            r_q     <= '0;
                            c_q     <= '0;
                            m_q     <= '0;
                        end
                    end
                    LD_IN: begin
                        if (in_ok) begin
                            state  <= LD_W;
                            w_ld_q <= 1'b1;
                        end
                    end
                    LD_W: begin
                        if (w_ok) begin
                            state  <= CONV;
                            conv_q <= 1'b1;
                            clr_q  <= (m_q == '0);
                        end
                    end
                    CONV: begin
                        if (conv_ok) begin
                            clr_q <= 1'b0;
                            if (m_q != M_LAST) begin
                                state   <= LD_IN;
                                in_ld_q <= 1'b1;
                                m_q     <= m_q + ONE;
                            end else begin
                                state <= ST;
                                st_q  <= 1'b1;
                            end
                        end
                    end
                    ST: begin
                        if (st_ok) begin
                            if (last_tile) begin
                                state  <= FIN;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                state   <= LD_IN;
                                in_ld_q <= 1'b1;
                                m_q     <= '0;
                                if (c_q != C_LAST) begin
                                    c_q <= c_q + ONE;
                                end else begin
                                    c_q <= '0;
                                    if (r_q != R_LAST) begin
                                        r_q <= r_q + ONE;
                                    end else begin
                                        r_q <= '0;
                                        n_q <= n_q + ONE;
                                    end
                                end
                            end
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sched_busy  = busy_q;
    assign bus.sched_done  = done_q;
    assign bus.in_ld_start = in_ld_q;
    assign bus.w_ld_start  = w_ld_q;
    assign bus.conv_start  = conv_q;
    assign bus.st_start    = st_q;
    assign bus.out_clr     = clr_q;
    assign bus.n_idx       = n_q;
    assign bus.r_idx       = r_q;
    assign bus.c_idx       = c_q;
    assign bus.m_idx       = m_q;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] busy_cyc;
    logic [31:0] conv_cyc;

    // Counters saturate rather than wrap so long layers still read sane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cyc <= '0;
            conv_cyc <= '0;
        end else if (start_ok) begin
            busy_cyc <= '0;
            conv_cyc <= '0;
        end else begin
            if (busy_q && (busy_cyc != '1)) begin
                busy_cyc <= busy_cyc + 32'd1;
            end
            if ((state == CONV) && (conv_cyc != '1)) begin
                conv_cyc <= conv_cyc + 32'd1;
            end
        end
    end

    assign bus.perf_busy_cyc = busy_cyc;
    assign bus.perf_conv_cyc = conv_cyc;
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched: cycle-exact vector table plus scoreboarded layers.
// Build with TILE_SCHED_PERF_EN to also exercise the perf counters.
module tb_conv_tile_sched;

    localparam int IW = 8;
    localparam int K  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_tile_sched_if #(.IW(IW)) bus ();

    conv_tile_sched #(
        .NR(K), .NC(K), .NM(K), .NN(K), .IW(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({bus.sched_busy, bus.in_ld_start, bus.w_ld_start,
                    bus.conv_start, bus.out_clr, bus.st_start,
                    bus.sched_done});
    endfunction

    function automatic logic [31:0] idx();
        return {bus.n_idx, bus.r_idx, bus.c_idx, bus.m_idx};
    endfunction

    // Done inputs: table-driven part OR responder part.
    logic t_in, t_w, t_cv, t_st;
    logic r_in, r_w, r_cv, r_st;
    assign bus.in_ld_done = t_in | r_in;
    assign bus.w_ld_done  = t_w | r_w;
    assign bus.conv_done  = t_cv | r_cv;
    assign bus.st_done    = t_st | r_st;

    typedef struct packed {
        logic       start, abort, ind, wd, cd, sd;
        logic [6:0] fl;
        logic [7:0] m;
    } vec_t;

    vec_t tbl[16];

    logic [31:0] cq[$];
    logic [31:0] sq[$];
    logic        mon_en = 1'b0;
    logic        resp_en = 1'b0;
    int ci, cw, cc, cs;
    int cnt_in, cnt_w, cnt_cv, cnt_st, cnt_done, cnt_clr;

    // Monitor/scoreboard and 3-cycle done responder.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            ci = 0; cw = 0; cc = 0; cs = 0;
            r_in = 0; r_w = 0; r_cv = 0; r_st = 0;
        end else begin
            if (mon_en) begin
                if (bus.in_ld_start) cnt_in++;
                if (bus.w_ld_start) cnt_w++;
                if (bus.conv_start) begin
                    cnt_cv++;
                    if (cq.size() == 0) chk("conv_q_empty", 32'd1, 32'd0);
                    else begin
                        logic [31:0] e;
                        e = cq.pop_front();
                        chk("conv_idx", idx(), e);
                        chk("conv_clr", 32'(bus.out_clr), 32'(e[7:0] == 8'd0));
                    end
                end
                if (bus.st_start) begin
                    cnt_st++;
                    if (sq.size() == 0) chk("st_q_empty", 32'd1, 32'd0);
                    else chk("st_idx", idx(), sq.pop_front());
                end
                if (bus.out_clr) begin
                    cnt_clr++;
                    chk("clr_m0", 32'(bus.m_idx), 32'd0);
                end
                if (bus.sched_done) begin
                    cnt_done++;
                    chk("done_busy", 32'(bus.sched_busy), 32'd0);
                end
            end
            if (resp_en) begin
                r_in = 0; r_w = 0; r_cv = 0; r_st = 0;
                if (ci > 0) begin ci--; if (ci == 0) r_in = 1; end
                if (cw > 0) begin cw--; if (cw == 0) r_w = 1; end
                if (cc > 0) begin cc--; if (cc == 0) r_cv = 1; end
                if (cs > 0) begin cs--; if (cs == 0) r_st = 1; end
                if (bus.in_ld_start) ci = 3;
                if (bus.w_ld_start) cw = 3;
                if (bus.conv_start) cc = 3;
                if (bus.st_start) cs = 3;
            end
        end
    end

    task automatic clr_counts();
        cnt_in = 0; cnt_w = 0; cnt_cv = 0;
        cnt_st = 0; cnt_done = 0; cnt_clr = 0;
    endtask

    task automatic push_layer();
        cq.delete();
        sq.delete();
        for (int n = 0; n < K; n++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    for (int m = 0; m < K; m++)
                        cq.push_back({8'(n), 8'(r), 8'(c), 8'(m)});
                    sq.push_back({8'(n), 8'(r), 8'(c), 8'(K - 1)});
                end
    endtask

    task automatic pulse_start();
        bus.sched_start = 1'b1;
        @(posedge clk);
        #1;
        bus.sched_start = 1'b0;
    endtask

    task automatic wait_done(string name);
        for (int k = 0; k < 3000 && cnt_done == 0; k++) @(posedge clk);
        #3;
        chk(name, 32'(cnt_done), 32'd1);
    endtask

    task automatic chk_layer(string tag);
        repeat (5) @(posedge clk);
        #3;
        chk({tag, "_in"}, 32'(cnt_in), 32'd16);
        chk({tag, "_w"}, 32'(cnt_w), 32'd16);
        chk({tag, "_conv"}, 32'(cnt_cv), 32'd16);
        chk({tag, "_st"}, 32'(cnt_st), 32'd8);
        chk({tag, "_done"}, 32'(cnt_done), 32'd1);
        chk({tag, "_clr_cyc"}, 32'(cnt_clr), 32'd32);
        chk({tag, "_cq_left"}, 32'(cq.size()), 32'd0);
        chk({tag, "_busy_end"}, 32'(bus.sched_busy), 32'd0);
    endtask

`ifdef TILE_SCHED_PERF_EN
    conv_tile_sched_if #(.IW(IW)) pbus ();

    conv_tile_sched #(
        .NR(1), .NC(1), .NM(1), .NN(1), .IW(IW)
    ) pdut (
        .clk(clk),
        .rst(rst),
        .bus(pbus.master)
    );
`endif

    initial begin
        bus.sched_start = 0;
        bus.sched_abort = 0;
        {t_in, t_w, t_cv, t_st} = '0;
        {r_in, r_w, r_cv, r_st} = '0;
        clr_counts();
`ifdef TILE_SCHED_PERF_EN
        pbus.sched_start = 0;
        pbus.sched_abort = 0;
        pbus.in_ld_done = 0;
        pbus.w_ld_done = 0;
        pbus.conv_done = 0;
        pbus.st_done = 0;
`endif
        // {start,abort,in_done,w_done,conv_done,st_done}, then flags
        // {busy,in_ld,w_ld,conv,clr,st,done} and m_idx seen next cycle.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1000000, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010000, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000000, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1001100, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000100, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1100000, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010000, 8'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1001000, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000010, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 8'd1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 8'd0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", flags(), 32'd0);
        chk("rst_idx", idx(), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            bus.sched_start = tbl[i].start;
            bus.sched_abort = tbl[i].abort;
            t_in = tbl[i].ind;
            t_w = tbl[i].wd;
            t_cv = tbl[i].cd;
            t_st = tbl[i].sd;
            @(posedge clk);
            #1;
            bus.sched_start = 0;
            bus.sched_abort = 0;
            {t_in, t_w, t_cv, t_st} = '0;
            chk($sformatf("vec%0d_flags", i), flags(), 32'(tbl[i].fl));
            chk($sformatf("vec%0d_idx", i), idx(), 32'(tbl[i].m));
        end

        // Full layer, with a stray start while in CONV.
        clr_counts();
        push_layer();
        mon_en = 1'b1;
        resp_en = 1'b1;
        pulse_start();
        for (int k = 0; k < 500 && cnt_cv < 5; k++) begin
            @(posedge clk);
            #2;
        end
        #1;
        chk("mid_conv_reached", 32'(cnt_cv), 32'd5);
        bus.sched_start = 1'b1;
        @(posedge clk);
        #1;
        bus.sched_start = 1'b0;
        wait_done("layer1_done_seen");
        chk_layer("layer1");

        // Async reset in the middle of CONV, then a clean rerun.
        clr_counts();
        push_layer();
        pulse_start();
        for (int k = 0; k < 500 && cnt_cv < 3; k++) begin
            @(posedge clk);
            #3;
        end
        chk("rst_conv_reached", 32'(cnt_cv), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_flags", flags(), 32'd0);
        chk("midrst_idx", idx(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clr_counts();
        push_layer();
        pulse_start();
        wait_done("layer2_done_seen");
        chk_layer("layer2");

`ifdef TILE_SCHED_PERF_EN
        begin
            logic pi, pw, pc, ps, seen;
            pi = 0; pw = 0; pc = 0; ps = 0; seen = 0;
            pbus.sched_start = 1'b1;
            @(posedge clk);
            #1;
            pbus.sched_start = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                pbus.in_ld_done = pi;
                pbus.w_ld_done = pw;
                pbus.conv_done = pc;
                pbus.st_done = ps;
                pi = pbus.in_ld_start;
                pw = pbus.w_ld_start;
                pc = pbus.conv_start;
                ps = pbus.st_start;
                @(posedge clk);
                #1;
                if (pbus.sched_done) seen = 1;
            end
            pbus.in_ld_done = 0;
            pbus.w_ld_done = 0;
            pbus.conv_done = 0;
            pbus.st_done = 0;
            chk("perf_done_seen", 32'(seen), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            chk("perf_busy_cyc", pbus.perf_busy_cyc, 32'd8);
            chk("perf_conv_cyc", pbus.perf_conv_cyc, 32'd2);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
